// File: rtl/mux_arb_pkg.sv
// Shared constants, state encoding and helpers for the round-robin mux arbiter.
package mux_arb_pkg;

  localparam int unsigned NREQ = 4;
  localparam int unsigned SW   = 2;

  typedef enum logic {IDLE, GRANT} state_e;

  function automatic logic [NREQ-1:0] onehot(input logic [SW-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority pick: first asserted request scanning ptr+1 .. ptr (mod 4).
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [SW-1:0]   ptr,
  output logic [SW-1:0]   idx,
  output logic            any
);

  logic [SW-1:0] cand;

  always_comb begin
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    // k == NREQ wraps to ptr itself, so the previous owner is scanned last
    for (int k = 1; k <= NREQ; k++) begin
      cand = ptr + SW'(k);
      if (!any && req[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving a shared 4:1 data mux; grant, select and the
// selected data are all registered.
module mux_rr_arbiter #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned DW       = 1,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DW-1:0]   t,
  output logic [1:0]           s,
  output logic [NREQ-1:0]      gnt,
  output logic [DW-1:0]        y,
  output logic                 y_vld,
  output logic                 busy
);

  import mux_arb_pkg::*;

  localparam logic [3:0] MaxHold = 4'(MAX_HOLD);

  state_e            state_q;
  logic [SW-1:0]     ptr_q;
  logic [3:0]        hold_cnt_q;
  logic [NREQ-1:0]   gnt_q;
  logic [SW-1:0]     s_q;
  logic [DW-1:0]     y_q;
  logic              y_vld_q;

  logic [SW-1:0]     pick_ptr;
  logic [SW-1:0]     pick_idx;
  logic              pick_any;
  logic              owner_req;
  logic              release_grant;
  logic [3:0]        hold_inc;
  logic [DW-1:0]     owner_data;

  always_comb begin
    // On release the owner becomes the new last-granted index for this same edge
    pick_ptr      = (state_q == GRANT) ? s_q : ptr_q;
    owner_req     = req[s_q];
    hold_inc      = hold_cnt_q + 4'd1;
    release_grant = !owner_req || (hold_inc == MaxHold);
    owner_data    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (s_q == SW'(i)) owner_data = t[i*DW +: DW];
    end
  end

  rr_pick u_rr_pick (
    .req (req),
    .ptr (pick_ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= SW'(NREQ - 1);
      hold_cnt_q <= '0;
      gnt_q      <= '0;
      s_q        <= '0;
      y_q        <= '0;
      y_vld_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          y_vld_q <= 1'b0;
          if (pick_any) begin
            state_q    <= GRANT;
            gnt_q      <= onehot(pick_idx);
            s_q        <= pick_idx;
            hold_cnt_q <= '0;
          end
        end
        GRANT: begin
          y_vld_q <= owner_req;
          if (owner_req) y_q <= owner_data;
          if (!release_grant) begin
            hold_cnt_q <= hold_inc;
          end else begin
            ptr_q      <= s_q;
            hold_cnt_q <= '0;
            if (pick_any) begin
              gnt_q <= onehot(pick_idx);
              s_q   <= pick_idx;
            end else begin
              state_q <= IDLE;
              gnt_q   <= '0;
              s_q     <= '0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt   = gnt_q;
  assign s     = s_q;
  assign y     = y_q;
  assign y_vld = y_vld_q;
  assign busy  = |gnt_q;

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Shares the 4:1 data mux between four requesters using rotating (round-robin) priority.
- Each requester presents its data slice on t and raises req; the arbiter drives the mux select s and the one-hot grant gnt, and registers the selected data onto y with a valid strobe.
- Sits in front of the mux datapath as its only select source.

Parameters:
- NREQ, 4, number of requesters. Fixed at 4; the select is 2 bits.
- DW, 1, data width per requester slice.
- MAX_HOLD, 4, maximum transfers per grant before re-arbitration. Legal range 1..15.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  NREQ  request per requester, level-sensitive.
- t  input  NREQ*DW  data; slice i is t[i*DW +: DW].
- s  output  2  mux select; equals the granted index, 0 when idle.
- gnt  output  NREQ  one-hot grant, all-zero when idle.
- y  output  DW  registered selected data.
- y_vld  output  1  y holds a transfer captured at the previous edge.
- busy  output  1  gnt != 0.

Behaviour:
- Reset (async, immediate, no clock needed):
  - gnt=0, s=0, y=0, y_vld=0, busy=0.
  - State IDLE, hold_cnt=0, ptr=3 (last-granted index), so index 0 has first priority.
- Registers: all outputs are registered; nothing combinational from req or t reaches an output.
- Pick function: the first asserted req scanning ptr+1, ptr+2, ptr+3, ptr (mod 4). The previous owner therefore has lowest priority.
- IDLE state:
  - Any req high at an edge: go to GRANT, gnt<=onehot(pick), s<=pick, hold_cnt<=0.
  - Otherwise stay in IDLE.
- GRANT state, owner i, at each edge:
  - Transfer: if req[i]=1, then y<=t slice i, y_vld<=1, hold_cnt+1. Otherwise y_vld<=0 and y holds its value.
  - Release: occurs when req[i]=0, or when this edge completes transfer number MAX_HOLD.
  - On release, ptr<=i and re-arbitrate at the same edge using the current req. There is no idle bubble in gnt.
    - A new pick gets gnt/s at once, with hold_cnt<=0.
    - If no request remains, go to IDLE with gnt<=0 and s<=0.
  - If i is the only requester at a MAX_HOLD release, i is re-granted: gnt stays constant, hold_cnt returns to 0, and y_vld stays continuously high.
- Latency: request to grant is 1 edge. The grant edge to the first y_vld is 1 further edge.
- A request dropped while not granted is simply not served; there is no request latching.
- t may change every cycle; y reflects t as sampled at the capture edge.
- ptr wraps 3->0.
- Reset asserted mid-GRANT aborts the transfer; no partial state survives.

Decomposition:
- Package mux_arb_pkg holds:
  - constants NREQ=4 and SW=2;
  - the state enum {IDLE, GRANT};
  - a function onehot(idx).
- Sub-module rr_pick: purely combinational.
  - Inputs: req[3:0], ptr[1:0].
  - Outputs: idx[1:0], any.
  - It is the only arbitration logic; the top module holds the FSM, hold counter and output registers.

Test Plan:
- Reset and idle: hold rst_n=0 for 3 edges, then release with req=0000 for 5 edges. Required: gnt=0000, s=0, y=0, y_vld=0, busy=0 throughout.
- Single requester: req=0100, t=4'b0100 held constant, MAX_HOLD=4. Required:
  - edge1: gnt=0100, s=2;
  - edge2 onward: y=1, y_vld=1;
  - gnt stays 0100 across the MAX_HOLD re-grant, and y_vld never drops.
- Full contention: req=1111, t=4'b1001, MAX_HOLD=4. Required:
  - gnt sequence 0001, 0010, 0100, 1000, 0001, each held for 4 edges;
  - y runs of 1,0,0,1 matching the owner;
  - y_vld high continuously from edge2.
- Early drop: req=0011, owner 0 deasserts req[0] after 2 transfers. Required:
  - at that edge, gnt=0010 and s=1 with no IDLE cycle;
  - y_vld is low for exactly 1 cycle, then y=t[1].
- Wrap fairness: owner 3 releases with req=1001. Required: next gnt=0001 (index 0 beats previous owner 3), ptr=3.
- Asynchronous reset mid-grant: drop rst_n between edges while gnt=0010 and y_vld=1. Required:
  - all outputs go to 0 before the next clock edge;
  - after release with req=1010, the first grant is gnt=0010 (ptr=3 gives index 1 priority over 3).
